// File: rtl/dac_seq_pkg.sv
// Purpose: shared state encoding and default sizing for the DAC sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_seq_pkg;

  localparam int NPH_DEF = 4;
  localparam int CW_DEF  = 32;
  localparam int PW_DEF  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dac_sync_gen.sv
// Purpose: turns the SPI completion level into a one-cycle DAC latch strobe.
// Latency: combinational from the spi_done rising edge (same cycle).
// Backpressure: none; a held spi_done yields a single strobe.
module dac_sync_gen (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic spi_done,
  output logic dac_sync,
  output logic done_rise
);

  logic spi_done_q;

  // Remember last cycle's spi_done so only its rising edge is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spi_done_q <= 1'b0;
    else     spi_done_q <= spi_done;
  end

  assign done_rise = spi_done & ~spi_done_q;
  assign dac_sync  = busy & done_rise;

endmodule

// File: rtl/dac_sequencer.sv
// Purpose: steps through per-phase timing slots, issuing SPI/ADC/DAC strobes per update.
// Latency: strobes and done are combinational in the cycle they apply; aborted is one cycle after abort.
// Backpressure: none; a late spi_done is flagged via sticky spi_overrun instead of stalling.
module dac_sequencer
  import dac_seq_pkg::*;
#(
  parameter int NPH = NPH_DEF,
  parameter int CW  = CW_DEF,
  parameter int PW  = PW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adc_en,
  input  logic [$clog2(NPH+1)-1:0] nph_used,
  input  logic [NPH*CW-1:0]        t_dur,
  input  logic [NPH*CW-1:0]        t_smp,
  input  logic [PW-1:0]            nsam,
  input  logic                     trigger,
  input  logic                     abort,
  input  logic                     spi_done,
  output logic                     spi_trigger,
  output logic                     adc_trigger,
  output logic                     dac_sync,
  output logic                     done,
  output logic                     aborted,
  output logic                     busy,
  output logic [$clog2(NPH)-1:0]   phase,
  output logic [PW-1:0]            dac_ptr,
  output logic                     spi_overrun
);

  localparam int NW  = $clog2(NPH+1);
  localparam int PHW = $clog2(NPH);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          spi_pend;
  logic          done_rise;
  logic          accept;
  logic [NW-1:0] nph_eff;
  logic [CW-1:0] dur_sel;
  logic [CW-1:0] smp_sel;
  logic [CW-1:0] dur_eff;
  logic [PW-1:0] nsam_eff;
  logic          at_bound;
  logic          at_last_ph;
  logic          at_last_smp;

  // Live per-phase field selection; zero settings are treated as one.
  assign dur_sel  = t_dur[phase*CW +: CW];
  assign smp_sel  = t_smp[phase*CW +: CW];
  assign dur_eff  = (dur_sel == '0) ? CW'(1) : dur_sel;
  assign nsam_eff = (nsam == '0) ? PW'(1) : nsam;
  assign nph_eff  = (nph_used == '0)       ? NW'(1)   :
                    (nph_used > NW'(NPH))  ? NW'(NPH) : nph_used;

  // Settings are live, so ">=" lets a shrink below the current position
  // end the slot/run at the next boundary instead of running to wrap.
  assign at_bound    = (cnt >= dur_eff - CW'(1));
  assign at_last_ph  = (NW'(phase) >= nph_eff - NW'(1));
  assign at_last_smp = (dac_ptr >= nsam_eff - PW'(1));

  assign busy        = (state == RUN);
  assign accept      = (state == IDLE) && trigger;
  assign spi_trigger = busy && (cnt == '0);
  assign adc_trigger = busy && adc_en && (cnt == smp_sel) && (smp_sel < dur_eff);
  assign done        = busy && !abort && at_bound && at_last_smp;

  // Sequencer FSM: slot counter, phase rotation and sample pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      phase   <= '0;
      dac_ptr <= '0;
      aborted <= 1'b0;
    end else begin
      aborted <= busy && abort;
      case (state)
        IDLE: begin
          cnt     <= '0;
          phase   <= '0;
          dac_ptr <= '0;
          if (trigger) state <= RUN;
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= '0;
            dac_ptr <= '0;
          end else if (at_bound) begin
            cnt <= '0;
            if (at_last_smp) begin
              state   <= IDLE;
              phase   <= '0;
              dac_ptr <= '0;
            end else begin
              dac_ptr <= dac_ptr + PW'(1);
              phase   <= at_last_ph ? '0 : phase + PHW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track an outstanding SPI write; a new write before its completion edge is an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_pend    <= 1'b0;
      spi_overrun <= 1'b0;
    end else if (accept) begin
      spi_pend    <= 1'b0;
      spi_overrun <= 1'b0;
    end else if (spi_trigger) begin
      if (spi_pend && !done_rise) spi_overrun <= 1'b1;
      spi_pend <= 1'b1;
    end else if (done_rise) begin
      spi_pend <= 1'b0;
    end
  end

  dac_sync_gen u_sync (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .spi_done  (spi_done),
    .dac_sync  (dac_sync),
    .done_rise (done_rise)
  );

endmodule

// File: tb/tb_dac_sequencer.sv
// Bench for dac_sequencer: per-scenario tasks, reference schedule built from slot rules.
module tb_dac_sequencer;

  localparam int NPH = 4;
  localparam int CW  = 32;
  localparam int PW  = 16;

  logic clk = 1'b0;
  logic rst, adc_en, trigger, abort, spi_done;
  logic [2:0]        nph_used;
  logic [NPH*CW-1:0] t_dur, t_smp;
  logic [PW-1:0]     nsam;
  logic spi_trigger, adc_trigger, dac_sync, done, aborted, busy, spi_overrun;
  logic [1:0]        phase;
  logic [PW-1:0]     dac_ptr;

  int errors = 0;
  int checks = 0;

  int dur_a[NPH];
  int smp_a[NPH];
  int cfg_nu, cfg_ns;
  bit cfg_ae;

  bit q_spi[$];
  bit q_adc[$];
  bit q_done[$];
  int q_ph[$];
  int q_ptr[$];

  logic [63:0] obs_spi_m, obs_adc_m, obs_done_m, obs_ph_seq, obs_ptr_seq;
  int          obs_sync;
  logic        obs_ab_post, obs_busy_post, obs_ovr0, obs_ovr_end;

  logic ovr_exp, outst, sd_prev;

  always #5 clk = ~clk;

  dac_sequencer #(.NPH(NPH), .CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .adc_en(adc_en), .nph_used(nph_used),
    .t_dur(t_dur), .t_smp(t_smp), .nsam(nsam), .trigger(trigger),
    .abort(abort), .spi_done(spi_done), .spi_trigger(spi_trigger),
    .adc_trigger(adc_trigger), .dac_sync(dac_sync), .done(done),
    .aborted(aborted), .busy(busy), .phase(phase), .dac_ptr(dac_ptr),
    .spi_overrun(spi_overrun)
  );

  task automatic apply_cfg(input int nu, input int ns, input bit ae);
    cfg_nu = nu; cfg_ns = ns; cfg_ae = ae;
    nph_used = 3'(nu);
    nsam     = PW'(ns);
    adc_en   = ae;
    for (int k = 0; k < NPH; k++) begin
      t_dur[k*CW +: CW] = CW'(dur_a[k]);
      t_smp[k*CW +: CW] = CW'(smp_a[k]);
    end
  endtask

  // Expected per-cycle trace: each update occupies max(dur,1) cycles of its phase.
  task automatic build_sched();
    int ne, ns, p, d;
    q_spi.delete(); q_adc.delete(); q_done.delete(); q_ph.delete(); q_ptr.delete();
    ne = (cfg_nu == 0) ? 1 : ((cfg_nu > NPH) ? NPH : cfg_nu);
    ns = (cfg_ns == 0) ? 1 : cfg_ns;
    for (int u = 0; u < ns; u++) begin
      p = u % ne;
      d = (dur_a[p] == 0) ? 1 : dur_a[p];
      for (int c = 0; c < d; c++) begin
        q_spi.push_back(c == 0);
        q_adc.push_back(cfg_ae && (c == smp_a[p]));
        q_done.push_back((u == ns - 1) && (c == d - 1));
        q_ph.push_back(p);
        q_ptr.push_back(u);
      end
    end
  endtask

  // mode: 0 = spi_done low, 1 = random spi_done/trigger noise, 2 = spi_done held run cycles 1..4
  task automatic do_run(input string nm, input int abort_at, input int mode);
    int n;
    bit ab, rise;
    logic [24:0] got, exp;
    build_sched();
    n = q_spi.size();
    obs_spi_m = '0; obs_adc_m = '0; obs_done_m = '0; obs_ph_seq = '0; obs_ptr_seq = '0;
    obs_sync = 0;
    trigger  = 1'b1;
    abort    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    spi_done = 1'b0;
    @(posedge clk); #1;
    trigger = 1'b0; ovr_exp = 1'b0; outst = 1'b0; sd_prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      ab    = (i == abort_at);
      abort = ab;
      case (mode)
        1:       spi_done = 1'($urandom_range(0, 1));
        2:       spi_done = (i >= 1) && (i <= 4);
        default: spi_done = 1'b0;
      endcase
      trigger = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      rise = spi_done && !sd_prev;
      exp = {1'b1, q_spi[i], q_adc[i], q_done[i] && !ab, 1'b0, rise, ovr_exp,
             2'(q_ph[i]), 16'(q_ptr[i])};
      @(negedge clk);
      got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, i, got, exp);
      end
      if (i == 0) obs_ovr0 = spi_overrun;
      if (i < 64) begin
        if (spi_trigger) begin
          obs_spi_m[i] = 1'b1;
          obs_ph_seq  = {obs_ph_seq[59:0], 2'b00, phase};
          obs_ptr_seq = {obs_ptr_seq[59:0], dac_ptr[3:0]};
        end
        if (adc_trigger) obs_adc_m[i] = 1'b1;
        if (done)        obs_done_m[i] = 1'b1;
      end
      if (dac_sync) obs_sync++;
      if (q_spi[i]) begin
        if (outst && !rise) ovr_exp = 1'b1;
        outst = 1'b1;
      end else if (rise) begin
        outst = 1'b0;
      end
      sd_prev = spi_done;
      @(posedge clk); #1;
      if (ab) break;
    end
    abort = 1'b0; trigger = 1'b0; spi_done = 1'b0;
    exp = {4'b0000, (abort_at >= 0) && (abort_at < n), 1'b0, ovr_exp, 2'b00, 16'h0000};
    @(negedge clk);
    got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s end: got %h expected %h", nm, got, exp);
    end
    obs_ab_post = aborted; obs_busy_post = busy; obs_ovr_end = spi_overrun;
    sd_prev = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_alt();
    dur_a = '{3, 5, 7, 7};
    smp_a = '{1, 2, 0, 0};
    apply_cfg(2, 4, 1'b1);
  endtask

  task automatic test_reset();
    logic [24:0] got;
    rst = 1'b1; trigger = 1'b1; abort = 1'b0; spi_done = 1'b1;
    set_alt();
    @(negedge clk);
    got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
    checks++;
    if (got !== 25'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", got); end
    @(posedge clk); #1;
    rst = 1'b0; trigger = 1'b0; spi_done = 1'b0;
    @(negedge clk);
    got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
    checks++;
    if (got !== 25'h0) begin errors++; $display("FAIL reset_idle: got %h expected 0", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_alternating();
    set_alt();
    do_run("alt", -1, 0);
    checks++;
    if (obs_spi_m !== 64'h0909) begin errors++; $display("FAIL alt_spi_cycles: got %h expected 0909", obs_spi_m); end
    checks++;
    if (obs_adc_m !== 64'h2222) begin errors++; $display("FAIL alt_adc_cycles: got %h expected 2222", obs_adc_m); end
    checks++;
    if (obs_done_m !== 64'h8000) begin errors++; $display("FAIL alt_done_cycle: got %h expected 8000", obs_done_m); end
    checks++;
    if (obs_ph_seq !== 64'h0101) begin errors++; $display("FAIL alt_phase_seq: got %h expected 0101", obs_ph_seq); end
  endtask

  task automatic test_three_phase();
    dur_a = '{2, 2, 2, 9};
    smp_a = '{0, 1, 3, 0};
    apply_cfg(3, 7, 1'b1);
    do_run("wrap3", -1, 0);
    checks++;
    if (obs_ph_seq !== 64'h0120120) begin errors++; $display("FAIL wrap3_phase_seq: got %h expected 0120120", obs_ph_seq); end
    checks++;
    if (obs_ptr_seq !== 64'h0123456) begin errors++; $display("FAIL wrap3_ptr_seq: got %h expected 0123456", obs_ptr_seq); end
    checks++;
    if (obs_done_m !== 64'h2000) begin errors++; $display("FAIL wrap3_done: got %h expected 2000", obs_done_m); end
    checks++;
    if (obs_adc_m !== 64'h1249) begin errors++; $display("FAIL wrap3_adc: got %h expected 1249", obs_adc_m); end
    checks++;
    if (obs_busy_post !== 1'b0) begin errors++; $display("FAIL wrap3_busy_after: got %b expected 0", obs_busy_post); end
  endtask

  task automatic test_abort();
    set_alt();
    do_run("abort", 6, 0);
    checks++;
    if (obs_ab_post !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", obs_ab_post); end
    checks++;
    if (obs_done_m !== 64'h0) begin errors++; $display("FAIL abort_no_done: got %h expected 0", obs_done_m); end
    do_run("restart", -1, 0);
    checks++;
    if (obs_ph_seq !== 64'h0101) begin errors++; $display("FAIL restart_phase_seq: got %h expected 0101", obs_ph_seq); end
  endtask

  task automatic test_degenerate();
    dur_a = '{0, 0, 0, 0};
    smp_a = '{0, 0, 0, 0};
    apply_cfg(2, 0, 1'b0);
    do_run("degen", -1, 0);
    checks++;
    if (obs_done_m !== 64'h1) begin errors++; $display("FAIL degen_done: got %h expected 1", obs_done_m); end
    checks++;
    if (obs_spi_m !== 64'h1) begin errors++; $display("FAIL degen_spi: got %h expected 1", obs_spi_m); end
    checks++;
    if (obs_adc_m !== 64'h0) begin errors++; $display("FAIL degen_adc: got %h expected 0", obs_adc_m); end
  endtask

  task automatic test_spi();
    set_alt();
    do_run("spi_held", -1, 2);
    checks++;
    if (obs_sync != 1) begin errors++; $display("FAIL spi_held_sync_count: got %0d expected 1", obs_sync); end
    do_run("spi_withheld", -1, 0);
    checks++;
    if (obs_ovr0 !== 1'b0) begin errors++; $display("FAIL overrun_cleared_by_trigger: got %b expected 0", obs_ovr0); end
    checks++;
    if (obs_ovr_end !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", obs_ovr_end); end
  endtask

  task automatic test_random();
    int ab;
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NPH; k++) begin
        dur_a[k] = $urandom_range(0, 6);
        smp_a[k] = $urandom_range(0, 7);
      end
      apply_cfg($urandom_range(0, 7), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      build_sched();
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, q_spi.size() - 1) : -1;
      do_run($sformatf("rand%0d", it), ab, 1);
    end
  endtask

  task automatic test_reset_midrun();
    logic [24:0] got;
    set_alt();
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
    checks++;
    if (got !== 25'h0) begin errors++; $display("FAIL midrun_reset_immediate: got %h expected 0", got); end
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin @(posedge clk); #1; rst = 1'b0; end
      @(negedge clk);
      got = {busy, spi_trigger, adc_trigger, done, aborted, dac_sync, spi_overrun, phase, dac_ptr};
      checks++;
      if (got !== 25'h0) begin errors++; $display("FAIL midrun_after_reset %0d: got %h expected 0", c, got); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alternating();
    test_three_phase();
    test_abort();
    test_degenerate();
    test_spi();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_sequencer.md
DAC_SEQUENCER -- requirements
Module: dac_sequencer

Interface
REQ-001 SHALL have parameter NPH, default 4: number of phase slots (2..16).
REQ-002 SHALL have parameter CW, default 32: width of the cycle counter and timing fields.
REQ-003 SHALL have parameter PW, default 16: width of the sample pointer.
REQ-004 SHALL provide these ports:
- clk  in  1: single clock.
- rst  in  1: asynchronous, active-high reset.
- adc_en  in  1: enables adc_trigger generation.
- nph_used  in  $clog2(NPH+1): number of active phases, 1..NPH.
- t_dur  in  NPH*CW: per-phase duration in cycles; slot k = bits [k*CW +: CW].
- t_smp  in  NPH*CW: per-phase ADC sample offset in cycles.
- nsam  in  PW: total DAC updates per run.
- trigger  in  1: start pulse.
- abort  in  1: stop request.
- spi_done  in  1: SPI transfer complete.
- spi_trigger  out  1: start DAC SPI write.
- adc_trigger  out  1: ADC sample strobe.
- dac_sync  out  1: DAC latch pulse.
- done  out  1: normal completion pulse.
- aborted  out  1: abort completion pulse.
- busy  out  1: high in RUN.
- phase  out  $clog2(NPH): current phase index.
- dac_ptr  out  PW: current sample index.
- spi_overrun  out  1: sticky error flag.

Function
REQ-005 SHALL implement FSM states IDLE and RUN; busy = (state==RUN).
REQ-006 IDLE SHALL hold cnt=0, phase=0, dac_ptr=0; trigger SHALL enter RUN on the next edge; trigger in RUN SHALL be ignored.
REQ-007 RUN SHALL increment cnt every cycle and pulse spi_trigger for exactly one cycle when cnt==0.
REQ-008 adc_trigger SHALL pulse one cycle when adc_en and cnt==t_smp[phase]; offsets >= the effective duration SHALL produce no pulse.
REQ-009 Effective duration SHALL be max(t_dur[phase],1); effective sample count SHALL be max(nsam,1); effective phase count SHALL be clamp(nph_used,1,NPH).
REQ-010 At cnt==duration-1, cnt SHALL reset to 0, dac_ptr SHALL increment, and phase SHALL advance, wrapping from nph-1 to 0.
REQ-011 At that boundary, if dac_ptr==nsam-1 then done SHALL pulse, dac_ptr and phase SHALL reset to 0, and the FSM SHALL return to IDLE.
REQ-012 abort in RUN SHALL return to IDLE on the next edge with aborted pulsed, no done, and cnt, phase and dac_ptr cleared.
- abort has priority over a coincident final boundary.
- abort in IDLE is ignored.
REQ-013 dac_sync SHALL pulse one cycle on each rising edge of spi_done while busy; a held spi_done SHALL yield one pulse.
REQ-014 spi_overrun SHALL set when spi_trigger asserts while the previous spi_trigger has not yet seen spi_done.
- Cleared only by an accepted trigger.
REQ-015 Counter compares SHALL be CW-bit unsigned; t_dur, t_smp and nsam SHALL be sampled live, with no shadowing.

Reset
REQ-016 rst SHALL asynchronously force state=IDLE and cnt=0, and drive every output to 0.
REQ-017 Reset asserted mid-run SHALL abandon the run with no done or aborted pulse.

Structure
REQ-018 Package dac_seq_pkg SHALL hold the state enum and the default NPH, CW and PW constants.
REQ-019 The dac_sync edge/pulse logic SHALL be sub-module dac_sync_gen.
REQ-020 Phase field selection SHALL use indexed part-select muxing; no combinational loops.

Verification
REQ-021 Alternating case: NPH=4, nph_used=2, t_dur={3,5}, t_smp={1,2}, nsam=4, adc_en=1, trigger.
- Required response: spi_trigger at run cycles 0, 3, 8, 11.
- adc_trigger at cycles 1, 5, 9, 13.
- done at cycle 15, phase sequence 0,1,0,1.
REQ-022 Three-phase wrap: nph_used=3, t_dur={2,2,2}, nsam=7.
- Required response: phase sequence 0,1,2,0,1,2,0 and dac_ptr 0..6.
- One done, then busy=0.
REQ-023 Abort: abort at run cycle 6 of REQ-021's setup.
- Required response: aborted on the next cycle, no done, dac_ptr=0.
- A new trigger restarts from phase 0.
REQ-024 Degenerate settings: t_dur=0, nsam=0, adc_en=0.
- Required response: one 1-cycle update, then done.
- No adc_trigger.
REQ-025 SPI handshake: spi_done held high for 4 cycles yields one dac_sync.
- Withholding spi_done across two spi_triggers sets spi_overrun, which clears on the next trigger.
REQ-026 Reset mid-run: assert rst at run cycle 2.
- Required response: all outputs 0 immediately; no done or aborted pulse.
